// File: rtl/if_prefetch_queue_pkg.sv
// Shared RISC-V front-end definitions: word width, the canonical NOP and the
// fetch-entry payload carried from fetch into decode.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Fetch/decode handshake bundle around the prefetch queue; the queue itself is
// the slave, the surrounding pipeline (fetch + decode + redirect) is the master.
interface if_prefetch_queue_if
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            i_fetch_valid;
    logic [XLEN-1:0] i_fetch_pc;
    logic [XLEN-1:0] i_fetch_inst;
    logic            o_fetch_ready;
    logic            o_id_valid;
    logic [XLEN-1:0] o_id_pc;
    logic [XLEN-1:0] o_id_inst;
    logic            i_id_ready;
    logic            i_flush;
    logic [CW-1:0]   o_count;

    modport master (
        output i_fetch_valid, i_fetch_pc, i_fetch_inst, i_id_ready, i_flush,
        input  o_fetch_ready, o_id_valid, o_id_pc, o_id_inst, o_count
    );

    modport slave (
        input  i_fetch_valid, i_fetch_pc, i_fetch_inst, i_id_ready, i_flush,
        output o_fetch_ready, o_id_valid, o_id_pc, o_id_inst, o_count
    );

endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode: strict FIFO, flushed on
// redirect, presenting a NOP at the head whenever it is empty.
module if_prefetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input logic                i_clk,
    input logic                i_rstn,
    if_prefetch_queue_if.slave q
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("if_prefetch_queue: DEPTH must be a power of two and >= 2");
    end

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Ready/valid depend on occupancy only, so a full queue never passes through.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = q.i_fetch_valid & ~full  & ~q.i_flush;
    assign pop   = q.i_id_ready    & ~empty & ~q.i_flush;

    assign q.o_fetch_ready = ~full;
    assign q.o_id_valid    = ~empty;
    assign q.o_id_pc       = empty ? '0       : mem[rd_ptr].pc;
    assign q.o_id_inst     = empty ? NOP_INST : mem[rd_ptr].inst;
    assign q.o_count       = count;

    // Pointers and occupancy; a redirect flush wins over any same-cycle push/pop.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is only qualified by occupancy, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: q.i_fetch_pc, inst: q.i_fetch_inst};
        end
    end

endmodule
